// File: rtl/knn_vote.sv
// Majority vote over the K nearest-neighbour labels read back from the KNN sorter.
// Define KNN_VOTE_WEIGHT_EN for a distance-weighted vote (nearest = K, farthest = 1).
`timescale 1ns/1ps

module knn_vote #(
    parameter int K       = 4,
    parameter int SEL_W   = 2,
    parameter int LABEL_W = 8,
    parameter int NCLASS  = 16,
    parameter int CNT_W   = 5
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    output logic [SEL_W-1:0]   sel,
    input  logic [LABEL_W-1:0] label_in,
    output logic               busy,
    output logic               valid,
    output logic [LABEL_W-1:0] class_out,
    output logic [CNT_W-1:0]   votes_out,
    output logic               invalid
);

    localparam int CLS_W  = $clog2(NCLASS);
    localparam int RANK_W = SEL_W + 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_READ,
        S_SCAN,
        S_OUT
    } state_t;

    state_t              state_q, state_d;
    logic [SEL_W-1:0]    sel_q, sel_d;
    logic [CLS_W-1:0]    scan_q, scan_d;
    logic [CNT_W-1:0]    cnt_q [NCLASS];
    logic [CNT_W-1:0]    cnt_d [NCLASS];
    logic [RANK_W-1:0]   rank_q [NCLASS];
    logic [RANK_W-1:0]   rank_d [NCLASS];
    logic                inv_acc_q, inv_acc_d;
    logic [CLS_W-1:0]    best_q, best_d;
    logic [CNT_W-1:0]    best_cnt_q, best_cnt_d;
    logic                busy_q, busy_d;
    logic                valid_q, valid_d;
    logic [LABEL_W-1:0]  class_q, class_d;
    logic [CNT_W-1:0]    votes_q, votes_d;
    logic                invalid_q, invalid_d;

    logic [CNT_W-1:0]    inc;
    logic                label_ok;
    logic [CLS_W-1:0]    label_idx;
    logic [CNT_W-1:0]    scan_cnt;
    logic                take;
    logic [CLS_W-1:0]    best_nx;
    logic [CNT_W-1:0]    best_cnt_nx;

    always_comb begin
`ifdef KNN_VOTE_WEIGHT_EN
        inc = CNT_W'(K) - CNT_W'(sel_q);
`else
        inc = CNT_W'(1);
`endif
        label_ok  = int'(label_in) < NCLASS;
        label_idx = label_in[CLS_W-1:0];

        // Equal non-zero counts fall to the class seen at the nearer neighbour rank.
        scan_cnt    = cnt_q[scan_q];
        take        = (scan_cnt > best_cnt_q) ||
                      ((scan_cnt == best_cnt_q) && (scan_cnt != '0) &&
                       (rank_q[scan_q] < rank_q[best_q]));
        best_nx     = take ? scan_q : best_q;
        best_cnt_nx = take ? scan_cnt : best_cnt_q;

        state_d    = state_q;
        sel_d      = sel_q;
        scan_d     = scan_q;
        cnt_d      = cnt_q;
        rank_d     = rank_q;
        inv_acc_d  = inv_acc_q;
        best_d     = best_q;
        best_cnt_d = best_cnt_q;
        busy_d     = busy_q;
        valid_d    = 1'b0;
        class_d    = class_q;
        votes_d    = votes_q;
        invalid_d  = invalid_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d   = S_READ;
                    busy_d    = 1'b1;
                    sel_d     = '0;
                    inv_acc_d = 1'b0;
                    for (int unsigned i = 0; i < NCLASS; i++) begin
                        cnt_d[i]  = '0;
                        rank_d[i] = RANK_W'(K);
                    end
                end
            end
            S_READ: begin
                if (label_ok) begin
                    cnt_d[label_idx] = cnt_q[label_idx] + inc;
                    if (rank_q[label_idx] == RANK_W'(K))
                        rank_d[label_idx] = {1'b0, sel_q};
                end else begin
                    inv_acc_d = 1'b1;
                end
                if (sel_q == SEL_W'(K - 1)) begin
                    state_d    = S_SCAN;
                    sel_d      = '0;
                    scan_d     = '0;
                    best_d     = '0;
                    best_cnt_d = '0;
                end else begin
                    sel_d = sel_q + 1'b1;
                end
            end
            S_SCAN: begin
                best_d     = best_nx;
                best_cnt_d = best_cnt_nx;
                // Last class is folded straight into the result so valid lands at E(K+NCLASS).
                if (scan_q == CLS_W'(NCLASS - 1)) begin
                    state_d   = S_OUT;
                    valid_d   = 1'b1;
                    class_d   = LABEL_W'(best_nx);
                    votes_d   = best_cnt_nx;
                    invalid_d = inv_acc_q;
                end else begin
                    scan_d = scan_q + 1'b1;
                end
            end
            S_OUT: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
            default: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            sel_q      <= '0;
            scan_q     <= '0;
            for (int unsigned i = 0; i < NCLASS; i++) begin
                cnt_q[i]  <= '0;
                rank_q[i] <= RANK_W'(K);
            end
            inv_acc_q  <= 1'b0;
            best_q     <= '0;
            best_cnt_q <= '0;
            busy_q     <= 1'b0;
            valid_q    <= 1'b0;
            class_q    <= '0;
            votes_q    <= '0;
            invalid_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            sel_q      <= sel_d;
            scan_q     <= scan_d;
            cnt_q      <= cnt_d;
            rank_q     <= rank_d;
            inv_acc_q  <= inv_acc_d;
            best_q     <= best_d;
            best_cnt_q <= best_cnt_d;
            busy_q     <= busy_d;
            valid_q    <= valid_d;
            class_q    <= class_d;
            votes_q    <= votes_d;
            invalid_q  <= invalid_d;
        end
    end

    assign sel       = sel_q;
    assign busy      = busy_q;
    assign valid     = valid_q;
    assign class_out = class_q;
    assign votes_out = votes_q;
    assign invalid   = invalid_q;

endmodule

// File: tb/tb_knn_vote.sv
// Directed bench for knn_vote: a behavioural sorter drives label_in from sel.
`timescale 1ns/1ps

module tb_knn_vote;

    localparam int K       = 4;
    localparam int SEL_W   = 2;
    localparam int LABEL_W = 8;
    localparam int NCLASS  = 16;
    localparam int CNT_W   = 5;

    logic               clk = 1'b0;
    logic               rst;
    logic               start;
    logic [SEL_W-1:0]   sel;
    logic [LABEL_W-1:0] label_in;
    logic               busy;
    logic               valid;
    logic [LABEL_W-1:0] class_out;
    logic [CNT_W-1:0]   votes_out;
    logic               invalid;

    logic [LABEL_W-1:0] lbls [K];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    assign label_in = lbls[sel];

    knn_vote #(
        .K(K), .SEL_W(SEL_W), .LABEL_W(LABEL_W), .NCLASS(NCLASS), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .sel(sel), .label_in(label_in),
        .busy(busy), .valid(valid), .class_out(class_out), .votes_out(votes_out),
        .invalid(invalid)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Runs one vote; extra > 0 pulses a second start that many edges after E0.
    task automatic run_vote(input logic [7:0] a, input logic [7:0] b,
                            input logic [7:0] c, input logic [7:0] d,
                            input int ec, input int ev, input int ei, input int extra);
        int   n;
        int   vcount;
        logic busy_ok;
        lbls[0] = a; lbls[1] = b; lbls[2] = c; lbls[3] = d;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        chk("busy_after_start", busy, 1);
        chk("sel_first", sel, 0);
        n = 0;
        busy_ok = 1'b1;
        while (n < 40 && !valid) begin
            if (extra != 0 && n == extra) start = 1'b1;
            @(posedge clk);
            #1;
            start = 1'b0;
            n++;
            if (!busy) busy_ok = 1'b0;
        end
        chk("latency", n, 20);
        chk("busy_held", busy_ok, 1);
        chk("class_out", class_out, ec);
        chk("votes_out", votes_out, ev);
        chk("invalid", invalid, ei);
        chk("sel_idle", sel, 0);
        @(posedge clk);
        #1;
        chk("valid_drop", valid, 0);
        chk("busy_drop", busy, 0);
        chk("class_hold", class_out, ec);
        chk("votes_hold", votes_out, ev);
        if (extra != 0) begin
            vcount = 0;
            repeat (25) begin
                @(posedge clk);
                #1;
                if (valid) vcount++;
            end
            chk("extra_valid", vcount, 0);
        end
    endtask

    initial begin
        int vcount;
        rst   = 1'b1;
        start = 1'b0;
        for (int i = 0; i < K; i++) lbls[i] = '0;
        repeat (2) @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_valid", valid, 0);
        chk("rst_sel", sel, 0);
        chk("rst_class", class_out, 0);
        chk("rst_votes", votes_out, 0);
        chk("rst_invalid", invalid, 0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

`ifdef KNN_VOTE_WEIGHT_EN
        run_vote(8'd3, 8'd3, 8'd7, 8'd1, 3, 7, 0, 0);
        run_vote(8'd5, 8'd2, 8'd2, 8'd5, 5, 5, 0, 0);
        run_vote(8'd9, 8'd9, 8'd9, 8'd9, 9, 10, 0, 10);
        run_vote(8'd20, 8'd4, 8'd200, 8'd20, 4, 3, 1, 0);
`else
        run_vote(8'd3, 8'd3, 8'd7, 8'd1, 3, 2, 0, 0);
        run_vote(8'd5, 8'd2, 8'd2, 8'd5, 5, 2, 0, 0);
        run_vote(8'd9, 8'd9, 8'd9, 8'd9, 9, 4, 0, 10);
        run_vote(8'd20, 8'd4, 8'd200, 8'd20, 4, 1, 1, 0);
`endif
        run_vote(8'd16, 8'd16, 8'd16, 8'd16, 0, 0, 1, 0);

        lbls[0] = 8'd6; lbls[1] = 8'd6; lbls[2] = 8'd1; lbls[3] = 8'd1;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        chk("abort_busy", busy, 0);
        chk("abort_valid", valid, 0);
        chk("abort_sel", sel, 0);
        chk("abort_class", class_out, 0);
        chk("abort_votes", votes_out, 0);
        chk("abort_invalid", invalid, 0);
        @(negedge clk);
        rst = 1'b0;
        vcount = 0;
        repeat (25) begin
            @(posedge clk);
            #1;
            if (valid) vcount++;
        end
        chk("abort_no_valid", vcount, 0);

`ifdef KNN_VOTE_WEIGHT_EN
        run_vote(8'd6, 8'd6, 8'd1, 8'd1, 6, 7, 0, 0);
        run_vote(8'd1, 8'd2, 8'd2, 8'd3, 2, 5, 0, 0);
        run_vote(8'd12, 8'd0, 8'd0, 8'd12, 12, 5, 0, 0);
        run_vote(8'd15, 8'd15, 8'd16, 8'd0, 15, 7, 1, 0);
`else
        run_vote(8'd6, 8'd6, 8'd1, 8'd1, 6, 2, 0, 0);
        run_vote(8'd1, 8'd2, 8'd2, 8'd3, 2, 2, 0, 0);
        run_vote(8'd12, 8'd0, 8'd0, 8'd12, 12, 2, 0, 0);
        run_vote(8'd15, 8'd15, 8'd16, 8'd0, 15, 2, 1, 0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
